// File: rtl/bus_client_mem_pkg.sv
// Shared definitions for the bus client memory: read/write encoding of wr_ni,
// wait-state counter width and the client FSM state encoding.
// No ports; imported by bus_client_mem and bus_client_mem_regfile.
package bus_client_mem_pkg;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } client_state_t;

endpackage

// File: rtl/bus_client_mem_regfile.sv
// Word storage for the bus client: MEM_DEPTH x DATA_WIDTH, async reset to zero.
// Latency: write commits on the clk edge with i_we high; read port is combinational.
// Ports: clk/rst, i_we/i_waddr/i_wdat write port, i_raddr/o_rdat read port.
module bus_client_mem_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdat,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdat
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // The caller only raises i_we for in-range addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/bus_client_mem.sv
// Bus client memory behind a four-phase rq/ack handshake with wait states and range error.
// Latency: ack rises WAIT_STATES edges after the capture edge (capture edge itself when 0).
// Backpressure: rq is held until ack; dropping rq during wait states aborts with no side effects.
// Ports: clk, reset (async high), address/wr_ni/dataW request fields, rq/ack handshake,
//        dataR registered read data, err out-of-range flag valid while ack is high.
module bus_client_mem
    import bus_client_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  rq,
    output logic                  ack,
    input  logic                  wr_ni,
    input  logic [DATA_WIDTH-1:0] dataW,
    output logic [DATA_WIDTH-1:0] dataR,
    output logic                  err
);

    if (WAIT_STATES < 0 || WAIT_STATES > 255) begin : g_bad_wait_states
        $error("bus_client_mem: WAIT_STATES must be in 0..255");
    end
    if (MEM_DEPTH < 1 || MEM_DEPTH > 2**ADDR_WIDTH) begin : g_bad_mem_depth
        $error("bus_client_mem: MEM_DEPTH must be in 1..2**ADDR_WIDTH");
    end

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]  LP_DEPTH    = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam bit                   LP_NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_LOAD = LP_NO_WAIT ? '0 : CNT_WIDTH'(WAIT_STATES - 1);

    client_state_t         r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_ack, r_err;
    logic [DATA_WIDTH-1:0] r_dataR;

    logic                  w_capture, w_finish;
    logic [ADDR_WIDTH-1:0] w_op_addr;
    logic                  w_op_rd;
    logic [DATA_WIDTH-1:0] w_op_dat;
    logic                  w_in_range;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdat;

    // With zero wait states the transaction completes on its capture edge, so
    // the operation fields come straight from the inputs while in IDLE.
    assign w_op_addr  = (r_state == ST_IDLE) ? address : r_addr;
    assign w_op_rd    = (r_state == ST_IDLE) ? wr_ni   : r_rd;
    assign w_op_dat   = (r_state == ST_IDLE) ? dataW   : r_dat;
    assign w_in_range = ({1'b0, w_op_addr} < LP_DEPTH);
    assign w_we       = w_finish && (w_op_rd == BUS_WRITE) && w_in_range;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rq) begin
                    w_capture = 1'b1;
                    if (LP_NO_WAIT) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!rq) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                if (!rq) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dataR <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_addr <= address;
                r_rd   <= wr_ni;
                r_dat  <= dataW;
            end
            r_ack <= (w_state_nxt == ST_ACK);
            if (w_finish) begin
                r_err <= !w_in_range;
                if (w_op_rd == BUS_READ) begin
                    r_dataR <= w_in_range ? w_rdat : '1;
                end
            end else if (r_state == ST_ACK && !rq) begin
                r_err <= 1'b0;
            end
        end
    end

    bus_client_mem_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (w_op_addr),
        .i_wdat  (w_op_dat),
        .i_raddr (w_op_addr),
        .o_rdat  (w_rdat)
    );

    assign ack   = r_ack;
    assign err   = r_err;
    assign dataR = r_dataR;

endmodule
